scan_chain_ctrl: RTL

- Tester-side controller that drives WIDTH parallel scan chains of CHAIN_LEN scan flops each.
- Per pattern: shifts stimulus in with se=1, issues one capture clock with se=0, then shifts the captured response out while the next pattern shifts in.
- After the last pattern, runs a final unload.
- Sits between a pattern source (stimulus stream) and a response sink, on the chain head/tail of the AES engine's scan-inserted registers.

---
 rtl/scan_chain_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/scan_chain_ctrl.sv
// Tester-side scan controller: shift stimulus into WIDTH parallel chains, capture, then overlap unload with the next load.
// Define SCAN_CMP_EN to build the response comparator and mismatch counter.
module scan_chain_ctrl #(
  parameter int WIDTH     = 8,
  parameter int CHAIN_LEN = 32,
  parameter int PAT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [PAT_W-1:0] num_patterns,
  input  logic             stim_valid,
  output logic             stim_ready,
  input  logic [WIDTH-1:0] stim_data,
  input  logic [WIDTH-1:0] exp_data,
  output logic             scan_se,
  output logic [WIDTH-1:0] scan_si,
  output logic             scan_clk_en,
  input  logic [WIDTH-1:0] scan_so,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WIDTH-1:0] resp_data,
  output logic             resp_last,
  output logic             busy,
  output logic             done,
  output logic [15:0]      mismatch_cnt
);

  localparam int CNT_W = $clog2(CHAIN_LEN);

  typedef enum logic [2:0] {S_IDLE, S_SHIFT, S_CAPTURE, S_UNLOAD, S_FIN} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_bit_cnt;
  logic [PAT_W-1:0] r_pat_cnt;
  logic [PAT_W-1:0] r_num_pat;
  logic             r_first;
  logic             r_resp_valid;
  logic [WIDTH-1:0] r_resp_data;
  logic             r_resp_last;
  logic             r_busy;
  logic             r_done;

  logic             w_resp_ok;
  logic             w_shift_fire;
  logic             w_unload_fire;
  logic             w_load;
  logic             w_bit_last;
  logic [PAT_W-1:0] w_pat_next;

  // The first pattern has no previous capture to unload, so it shifts regardless of the sink.
  assign w_resp_ok     = !r_resp_valid || resp_ready;
  assign stim_ready    = (r_state == S_SHIFT) && (w_resp_ok || r_first);
  assign w_shift_fire  = stim_valid && stim_ready;
  assign w_unload_fire = (r_state == S_UNLOAD) && w_resp_ok;
  assign w_load        = (w_shift_fire && !r_first) || w_unload_fire;
  assign w_bit_last    = (r_bit_cnt == CNT_W'(CHAIN_LEN - 1));
  assign w_pat_next    = r_pat_cnt + PAT_W'(1);

  // NOTE: combinational outputs get their default first so no path can infer a latch.
  always_comb begin
    scan_se     = 1'b0;
    scan_clk_en = 1'b0;
    scan_si     = '0;
    if (w_shift_fire) begin
      scan_se     = 1'b1;
      scan_clk_en = 1'b1;
      scan_si     = stim_data;
    end else if (w_unload_fire) begin
      scan_se     = 1'b1;
      scan_clk_en = 1'b1;
    end else if (r_state == S_CAPTURE) begin
      scan_clk_en = 1'b1;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_bit_cnt    <= '0;
      r_pat_cnt    <= '0;
      r_num_pat    <= '0;
      r_first      <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_last  <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;

      if (w_load) begin
        r_resp_valid <= 1'b1;
        r_resp_data  <= scan_so;
        r_resp_last  <= w_bit_last;
      end else if (resp_ready) begin
        r_resp_valid <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_num_pat <= num_patterns;
            r_bit_cnt <= '0;
            r_pat_cnt <= '0;
            r_first   <= 1'b1;
            r_busy    <= 1'b1;
            r_state   <= (num_patterns == '0) ? S_FIN : S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (w_shift_fire) begin
            r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + CNT_W'(1);
            if (w_bit_last) r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          r_pat_cnt <= w_pat_next;
          r_first   <= 1'b0;
          r_state   <= (w_pat_next == r_num_pat) ? S_UNLOAD : S_SHIFT;
        end
        S_UNLOAD: begin
          if (w_unload_fire) begin
            r_bit_cnt <= w_bit_last ? '0 : r_bit_cnt + CNT_W'(1);
            if (w_bit_last) r_state <= S_FIN;
          end
        end
        S_FIN: begin
          if (!r_resp_valid) begin
            r_done  <= 1'b1;
            r_busy  <= 1'b0;
            r_state <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_last  = r_resp_last;
  assign busy       = r_busy;
  assign done       = r_done;

`ifdef SCAN_CMP_EN
  logic [WIDTH-1:0] r_exp_buf [CHAIN_LEN];
  logic [WIDTH-1:0] r_exp_data;
  logic [15:0]      r_mismatch_cnt;
  logic             w_last_pat;

  assign w_last_pat = (r_pat_cnt == r_num_pat - PAT_W'(1));

  // NOTE: the expected-data buffer has no reset; each entry is written during the final load before UNLOAD reads it.
  always_ff @(posedge clk) begin
    if (w_shift_fire && w_last_pat) r_exp_buf[r_bit_cnt] <= exp_data;
  end

  // Expected slice travels with the response register and is judged when the sink takes the beat.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_exp_data     <= '0;
      r_mismatch_cnt <= '0;
    end else begin
      if (w_load) r_exp_data <= (r_state == S_UNLOAD) ? r_exp_buf[r_bit_cnt] : exp_data;
      if (r_state == S_IDLE && start) begin
        r_mismatch_cnt <= '0;
      end else if (r_resp_valid && resp_ready && (r_resp_data != r_exp_data) &&
                   (r_mismatch_cnt != 16'hFFFF)) begin
        r_mismatch_cnt <= r_mismatch_cnt + 16'd1;
      end
    end
  end

  assign mismatch_cnt = r_mismatch_cnt;
`else
  logic w_unused_exp;
  assign w_unused_exp = ^exp_data;
  assign mismatch_cnt = 16'h0000;
`endif

endmodule
